// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter sharing the data memory port between the core (r0) and loader/debug master (r1).
// Optional ownership lock for multi-word bursts is built only when DMEM_ARB_LOCK_EN is defined.
module dmem_arbiter #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            r0_req,
  input  logic [DW/8-1:0] r0_we,
  input  logic [AW-1:0]   r0_addr,
  input  logic [DW-1:0]   r0_wdata,
  input  logic            r0_lock,
  output logic            r0_gnt,
  output logic            r0_rvalid,
  output logic [DW-1:0]   r0_rdata,
  input  logic            r1_req,
  input  logic [DW/8-1:0] r1_we,
  input  logic [AW-1:0]   r1_addr,
  input  logic [DW-1:0]   r1_wdata,
  input  logic            r1_lock,
  output logic            r1_gnt,
  output logic            r1_rvalid,
  output logic [DW-1:0]   r1_rdata,
  output logic [DW/8-1:0] mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int unsigned BW = DW / 8;

  logic r_last;
  logic r_pend_vld;
  logic r_pend_id;

  logic w_allow0;
  logic w_allow1;
  logic w_cand0;
  logic w_cand1;
  logic w_gnt0;
  logic w_gnt1;
  logic w_gnt_rd;

`ifdef DMEM_ARB_LOCK_EN
  typedef enum logic [1:0] {
    OPEN = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } own_state_t;

  own_state_t r_state;
  own_state_t w_state_nxt;

  // An owner shuts out the other requester until it releases.
  assign w_allow0 = (r_state != OWN1);
  assign w_allow1 = (r_state != OWN0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= OPEN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      OPEN: begin
        if (w_gnt0 && r0_lock) begin
          w_state_nxt = OWN0;
        end else if (w_gnt1 && r1_lock) begin
          w_state_nxt = OWN1;
        end
      end
      // Ownership ends on an unlocked access or when the owner goes idle.
      OWN0: begin
        if (!r0_req || (w_gnt0 && !r0_lock)) begin
          w_state_nxt = OPEN;
        end
      end
      OWN1: begin
        if (!r1_req || (w_gnt1 && !r1_lock)) begin
          w_state_nxt = OPEN;
        end
      end
      default: begin
        w_state_nxt = OPEN;
      end
    endcase
  end
`else
  logic w_lock_unused;

  assign w_lock_unused = r0_lock ^ r1_lock;
  assign w_allow0      = 1'b1;
  assign w_allow1      = 1'b1;
`endif

  // Round-robin: on a tie the requester that did not win last time is granted.
  assign w_cand0 = r0_req & w_allow0;
  assign w_cand1 = r1_req & w_allow1;
  assign w_gnt0  = w_cand0 & (~w_cand1 | r_last);
  assign w_gnt1  = w_cand1 & (~w_cand0 | ~r_last);

  assign w_gnt_rd = (w_gnt0 && (r0_we == BW'(0))) || (w_gnt1 && (r1_we == BW'(0)));

  always_comb begin
    mem_we    = BW'(0);
    mem_addr  = AW'(0);
    mem_wdata = DW'(0);
    if (w_gnt0) begin
      mem_we    = r0_we;
      mem_addr  = r0_addr;
      mem_wdata = r0_wdata;
    end else if (w_gnt1) begin
      mem_we    = r1_we;
      mem_addr  = r1_addr;
      mem_wdata = r1_wdata;
    end
  end

  // Remember the last grantee and who owns the read returning next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last     <= 1'b1;
      r_pend_vld <= 1'b0;
      r_pend_id  <= 1'b0;
    end else begin
      if (w_gnt0 || w_gnt1) begin
        r_last <= w_gnt1;
      end
      r_pend_vld <= w_gnt_rd;
      r_pend_id  <= w_gnt1;
    end
  end

  assign r0_gnt    = w_gnt0;
  assign r1_gnt    = w_gnt1;
  assign r0_rvalid = r_pend_vld & ~r_pend_id;
  assign r1_rvalid = r_pend_vld & r_pend_id;
  assign r0_rdata  = mem_rdata;
  assign r1_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small byte-enabled memory and a read-return scoreboard.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        r0_req, r1_req;
  logic [3:0]  r0_we, r1_we;
  logic [31:0] r0_addr, r1_addr;
  logic [31:0] r0_wdata, r1_wdata;
  logic        r0_lock, r1_lock;
  logic        r0_gnt, r1_gnt;
  logic        r0_rvalid, r1_rvalid;
  logic [31:0] r0_rdata, r1_rdata;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:255];

  typedef struct {
    logic        id;
    logic [31:0] data;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  dmem_arbiter #(.AW(32), .DW(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .r0_req    (r0_req),
    .r0_we     (r0_we),
    .r0_addr   (r0_addr),
    .r0_wdata  (r0_wdata),
    .r0_lock   (r0_lock),
    .r0_gnt    (r0_gnt),
    .r0_rvalid (r0_rvalid),
    .r0_rdata  (r0_rdata),
    .r1_req    (r1_req),
    .r1_we     (r1_we),
    .r1_addr   (r1_addr),
    .r1_wdata  (r1_wdata),
    .r1_lock   (r1_lock),
    .r1_gnt    (r1_gnt),
    .r1_rvalid (r1_rvalid),
    .r1_rdata  (r1_rdata),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory: data appears the cycle after the address.
  always @(posedge clk) begin
    if (!rst) begin
      mem[4]    <= 32'hDEADBEEF;
      mem[5]    <= 32'hCAFEF00D;
      mem_rdata <= 32'h0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      mem_rdata <= mem[mem_addr[9:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set0(input logic req, input logic [3:0] we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic lock);
    r0_req = req; r0_we = we; r0_addr = addr; r0_wdata = wdata; r0_lock = lock;
  endtask

  task automatic set1(input logic req, input logic [3:0] we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic lock);
    r1_req = req; r1_we = we; r1_addr = addr; r1_wdata = wdata; r1_lock = lock;
  endtask

  // One cycle: check grants/memory drive, retire any pending read, queue new read expectation.
  task automatic cyc(input logic eg0, input logic eg1, input logic [31:0] eaddr,
                     input logic [3:0] ewe, input logic [31:0] erd);
    sb_t e;
    @(negedge clk);
    chk("r0_gnt", 32'(r0_gnt), 32'(eg0));
    chk("r1_gnt", 32'(r1_gnt), 32'(eg1));
    chk("mem_addr", mem_addr, eaddr);
    chk("mem_we", 32'(mem_we), 32'(ewe));
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("rvalid", 32'({r1_rvalid, r0_rvalid}), e.id ? 32'd2 : 32'd1);
      chk("rdata", e.id ? r1_rdata : r0_rdata, e.data);
    end else begin
      chk("no_rvalid", 32'({r1_rvalid, r0_rvalid}), 32'd0);
    end
    if (eg0 && r0_we == 4'h0) sb_q.push_back('{1'b0, erd});
    if (eg1 && r1_we == 4'h0) sb_q.push_back('{1'b1, erd});
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] wdat [0:3];
    for (int i = 0; i < 4; i++) wdat[i] = 32'hA0B0C000 | 32'(i);

    rst = 1'b0;
    set0(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    set1(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'({r1_gnt, r0_gnt}), 32'd0);
    chk("rst_rvalid", 32'({r1_rvalid, r0_rvalid}), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Lone read returns one cycle later.
    set0(1'b1, 4'h0, 32'h10, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 32'h10, 4'h0, 32'hDEADBEEF);
    set0(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    set1(1'b1, 4'h0, 32'h14, 32'h0, 1'b0);
    cyc(1'b0, 1'b1, 32'h14, 4'h0, 32'hCAFEF00D);

    // Continuous contention alternates 0,1,0,1.
    set0(1'b1, 4'h0, 32'h10, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 32'h10, 4'h0, 32'hDEADBEEF);
    cyc(1'b0, 1'b1, 32'h14, 4'h0, 32'hCAFEF00D);
    cyc(1'b1, 1'b0, 32'h10, 4'h0, 32'hDEADBEEF);
    cyc(1'b0, 1'b1, 32'h14, 4'h0, 32'hCAFEF00D);
    set0(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);

    // r1 write then r0 reads it back.
    set1(1'b1, 4'hF, 32'h20, 32'h12345678, 1'b0);
    cyc(1'b0, 1'b1, 32'h20, 4'hF, 32'h0);
    set1(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    set0(1'b1, 4'h0, 32'h20, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 32'h20, 4'h0, 32'h12345678);
    set0(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

`ifndef DMEM_ARB_LOCK_EN
    set1(1'b1, 4'h0, 32'h14, 32'h0, 1'b0);
    cyc(1'b0, 1'b1, 32'h14, 4'h0, 32'hCAFEF00D);
`endif

    // r1 burst: three locked writes then an unlocked one, r0 requesting throughout.
    set0(1'b1, 4'h0, 32'h10, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      set1(1'b1, 4'hF, 32'h30 + 32'(4 * i), wdat[i], (i < 3));
`ifdef DMEM_ARB_LOCK_EN
      cyc(1'b0, 1'b1, 32'h30 + 32'(4 * i), 4'hF, 32'h0);
`else
      cyc(1'b1, 1'b0, 32'h10, 4'h0, 32'hDEADBEEF);
      cyc(1'b0, 1'b1, 32'h30 + 32'(4 * i), 4'hF, 32'h0);
`endif
    end
    set1(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 32'h10, 4'h0, 32'hDEADBEEF);

    set0(1'b1, 4'h0, 32'h3C, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 32'h3C, 4'h0, wdat[3]);
    set0(1'b1, 4'h0, 32'h30, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 32'h30, 4'h0, wdat[0]);
    set0(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

    // Reset right after a granted read drops its return and restores last=1.
    set0(1'b1, 4'h0, 32'h10, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 32'h10, 4'h0, 32'hDEADBEEF);
    set0(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
    chk("midrst_rvalid", 32'({r1_rvalid, r0_rvalid}), 32'd0);
    chk("midrst_gnt", 32'({r1_gnt, r0_gnt}), 32'd0);
    chk("midrst_mem_addr", mem_addr, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    set0(1'b1, 4'h0, 32'h10, 32'h0, 1'b0);
    set1(1'b1, 4'h0, 32'h14, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 32'h10, 4'h0, 32'hDEADBEEF);
    set0(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    set1(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
